// File: rtl/alu_pkg.sv
// Shared definitions for the two-stage ALU pipeline: op encodings and the compare-flag bundle.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef struct packed {
    logic a_gt_b;
    logic a_eq_b;
    logic b_gt_a;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: op/a/b -> result, carry and unsigned compare flags.
// Optional saturation on add/subtract when ALU_PIPE_SAT_EN is defined.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output flags_t           flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Two's-complement subtract; the top bit is the no-borrow indication (a >= b).
    diff   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        carry  = sum[WIDTH];
        result = sum[WIDTH-1:0];
`ifdef ALU_PIPE_SAT_EN
        if (sum[WIDTH]) result = '1;
`endif
      end
      OP_SUB: begin
        carry  = diff[WIDTH];
        result = diff[WIDTH-1:0];
`ifdef ALU_PIPE_SAT_EN
        if (!diff[WIDTH]) result = '0;
`endif
      end
      OP_CMP: begin
        result = '0;
        carry  = 1'b0;
      end
      default: begin
        result = a & b;
        carry  = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags.a_gt_b = (a > b);
    flags.a_eq_b = (a == b);
    flags.b_gt_a = (b > a);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline (S1 operands, S2 result/flags) with a delivered-beat counter.
// Build option: define ALU_PIPE_SAT_EN for saturating add/subtract.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             b_gt_a,
  output logic [15:0]      beat_cnt
);

  // Handshake: a beat moves on a rising edge where valid && ready are both high;
  // a producer holds valid and data stable until that edge, ready may depend on out_ready.

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_carry;
  flags_t           s2_flags;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  flags_t           core_flags;

  logic s2_load;
  logic s1_adv;
  logic deliver;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = s1_adv;
  assign deliver  = s2_valid && out_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result),
    .carry  (core_carry),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_a  <= a;
        s1_b  <= b;
      end
    end
  end

  // S2 keeps its last payload when it drains empty; only out_valid is meaningful then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      s2_flags  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_carry  <= core_carry;
        s2_flags  <= core_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= 16'h0000;
    end else if (deliver) begin
      beat_cnt <= beat_cnt + 16'h0001;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign carry     = s2_carry;
  assign a_gt_b    = s2_flags.a_gt_b;
  assign a_eq_b    = s2_flags.a_eq_b;
  assign b_gt_a    = s2_flags.b_gt_a;

endmodule
